// File: rtl/mu0x_datapath.sv
// mu0x_datapath -- parametrised MU0 datapath with a 3-bit ALU mode set,
// a registered carry flag and a hardware return-address stack.
//
// Ports
//   Clk, Reset           rising-edge clock, synchronous active-high reset
//   Din                  memory read data
//   X_sel, Y_sel         ALU operand selects (X: Acc/PC, Y: Din/IR operand)
//   Addr_sel             memory address select (PC / IR operand)
//   PC_En, IR_En,
//   Acc_En, Flag_En      register load enables
//   M                    ALU mode
//   Push, Pop            return-stack control
//   F                    instruction opcode field
//   Address, Dout        memory address and write data (Dout = X)
//   N, Z, C              negative, zero (combinational) and carry (registered)
//   PC, Acc              program counter and accumulator
//   Stk_Empty, Stk_Full  stack occupancy
//   Stk_Err              sticky stack-misuse flag
//
// DATA_W must be at least ADDR_W+4 so the opcode field and the operand
// field of IR do not overlap.

module mu0x_datapath #(
  parameter int unsigned       DATA_W      = 16,
  parameter int unsigned       ADDR_W      = 12,
  parameter int unsigned       STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] PC_RESET    = '0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [DATA_W-1:0] Din,
  input  logic              X_sel,
  input  logic              Y_sel,
  input  logic              Addr_sel,
  input  logic              PC_En,
  input  logic              IR_En,
  input  logic              Acc_En,
  input  logic              Flag_En,
  input  logic [2:0]        M,
  input  logic              Push,
  input  logic              Pop,
  output logic [3:0]        F,
  output logic [ADDR_W-1:0] Address,
  output logic [DATA_W-1:0] Dout,
  output logic              N,
  output logic              Z,
  output logic              C,
  output logic [ADDR_W-1:0] PC,
  output logic [DATA_W-1:0] Acc,
  output logic              Stk_Empty,
  output logic              Stk_Full,
  output logic              Stk_Err
);

  // SP counts 0..STACK_DEPTH inclusive, so it needs one more code than
  // the entry index does.
  localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IDX_W = $clog2(STACK_DEPTH);
  localparam int unsigned EXT_W = DATA_W - ADDR_W;

  localparam logic [2:0] M_PASS = 3'b000;
  localparam logic [2:0] M_ADD  = 3'b001;
  localparam logic [2:0] M_INC  = 3'b010;
  localparam logic [2:0] M_SUB  = 3'b011;
  localparam logic [2:0] M_AND  = 3'b100;
  localparam logic [2:0] M_OR   = 3'b101;
  localparam logic [2:0] M_XOR  = 3'b110;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              c_q, c_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] stk_q [STACK_DEPTH];

  logic [DATA_W-1:0] x, y;
  logic [DATA_W-1:0] alu_res;
  logic              alu_c;
  logic [DATA_W:0]   wide;

  logic              stk_full, stk_empty;
  logic              push_ok, pop_ok, stk_misuse;
  logic [IDX_W-1:0]  push_idx, pop_idx;

  // Operand and address muxes
  assign x = X_sel ? {{EXT_W{1'b0}}, pc_q} : acc_q;
  assign y = Y_sel ? {{EXT_W{1'b0}}, ir_q[ADDR_W-1:0]} : Din;

  // ALU; carry comes from a DATA_W+1 bit result. For subtraction the top
  // bit of the extended difference is exactly the unsigned borrow.
  always_comb begin
    wide    = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    case (M)
      M_PASS: alu_res = y;
      M_ADD: begin
        wide    = {1'b0, x} + {1'b0, y};
        alu_res = wide[DATA_W-1:0];
        alu_c   = wide[DATA_W];
      end
      M_INC: begin
        wide    = {1'b0, x} + {{DATA_W{1'b0}}, 1'b1};
        alu_res = wide[DATA_W-1:0];
        alu_c   = wide[DATA_W];
      end
      M_SUB: begin
        wide    = {1'b0, x} - {1'b0, y};
        alu_res = wide[DATA_W-1:0];
        alu_c   = wide[DATA_W];
      end
      M_AND: alu_res = x & y;
      M_OR:  alu_res = x | y;
      M_XOR: alu_res = x ^ y;
      default: begin
        alu_res = {1'b0, x[DATA_W-1:1]};
        alu_c   = x[0];
      end
    endcase
  end

  // Return stack control. Any push/pop that cannot complete (including
  // both at once) leaves the stack untouched and raises the sticky error.
  assign stk_empty  = (sp_q == '0);
  assign stk_full   = (sp_q == SP_W'(STACK_DEPTH));
  assign push_ok    = Push & ~Pop & ~stk_full;
  assign pop_ok     = Pop & ~Push & ~stk_empty;
  assign stk_misuse = (Push & Pop) | (Push & stk_full) | (Pop & stk_empty);
  assign push_idx   = sp_q[IDX_W-1:0];
  assign pop_idx    = IDX_W'(sp_q - SP_W'(1));

  always_comb begin
    ir_d  = IR_En   ? Din     : ir_q;
    acc_d = Acc_En  ? alu_res : acc_q;
    c_d   = Flag_En ? alu_c   : c_q;
    sp_d  = sp_q;
    err_d = err_q | stk_misuse;
    pc_d  = PC_En ? alu_res[ADDR_W-1:0] : pc_q;
    if (push_ok) begin
      sp_d = sp_q + SP_W'(1);
    end
    if (pop_ok) begin
      sp_d = sp_q - SP_W'(1);
      pc_d = stk_q[pop_idx];   // return beats PC_En
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc_q  <= PC_RESET;
      acc_q <= '0;
      ir_q  <= '0;
      c_q   <= 1'b0;
      sp_q  <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      acc_q <= acc_d;
      ir_q  <= ir_d;
      c_q   <= c_d;
      sp_q  <= sp_d;
      err_q <= err_d;
    end
  end

  // Stack storage carries no reset; SP alone defines which entries are live.
  always_ff @(posedge Clk) begin
    if (!Reset && push_ok) begin
      stk_q[push_idx] <= pc_q;
    end
  end

  assign F         = ir_q[DATA_W-1 -: 4];
  assign Address   = Addr_sel ? ir_q[ADDR_W-1:0] : pc_q;
  assign Dout      = x;
  assign N         = acc_q[DATA_W-1];
  assign Z         = (acc_q == '0);
  assign C         = c_q;
  assign PC        = pc_q;
  assign Acc       = acc_q;
  assign Stk_Empty = stk_empty;
  assign Stk_Full  = stk_full;
  assign Stk_Err   = err_q;

endmodule

// File: tb/tb_mu0x_datapath.sv
module tb_mu0x_datapath;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [15:0] Din;
  logic        X_sel, Y_sel, Addr_sel;
  logic        PC_En, IR_En, Acc_En, Flag_En;
  logic [2:0]  M;
  logic        Push, Pop;
  logic [3:0]  F;
  logic [11:0] Address;
  logic [15:0] Dout;
  logic        N, Z, C;
  logic [11:0] PC;
  logic [15:0] Acc;
  logic        Stk_Empty, Stk_Full, Stk_Err;

  mu0x_datapath #(
    .DATA_W(16), .ADDR_W(12), .STACK_DEPTH(4), .PC_RESET(12'h000)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Din(Din),
    .X_sel(X_sel), .Y_sel(Y_sel), .Addr_sel(Addr_sel),
    .PC_En(PC_En), .IR_En(IR_En), .Acc_En(Acc_En), .Flag_En(Flag_En),
    .M(M), .Push(Push), .Pop(Pop),
    .F(F), .Address(Address), .Dout(Dout),
    .N(N), .Z(Z), .C(C), .PC(PC), .Acc(Acc),
    .Stk_Empty(Stk_Empty), .Stk_Full(Stk_Full), .Stk_Err(Stk_Err)
  );

  always #5 Clk = ~Clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state: plain integers and a queue for the stack.
  int m_pc, m_acc, m_ir, m_c, m_err;
  int m_stk[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("F",       32'(F),        32'((m_ir >> 12) & 'hF));
    check("Address", 32'(Address),  32'(Addr_sel ? (m_ir & 'hFFF) : m_pc));
    check("Dout",    32'(Dout),     32'(X_sel ? m_pc : m_acc));
    check("N",       32'(N),        32'((m_acc >> 15) & 1));
    check("Z",       32'(Z),        32'(m_acc == 0));
    check("C",       32'(C),        32'(m_c));
    check("PC",      32'(PC),       32'(m_pc));
    check("Acc",     32'(Acc),      32'(m_acc));
    check("Empty",   32'(Stk_Empty), 32'(m_stk.size() == 0));
    check("Full",    32'(Stk_Full),  32'(m_stk.size() == 4));
    check("Err",     32'(Stk_Err),   32'(m_err));
  endtask

  task automatic step(input logic rst, input logic xs, input logic ys, input logic as_,
                      input logic pce, input logic ire, input logic acce, input logic fe,
                      input logic [2:0] m, input logic psh, input logic pp,
                      input logic [15:0] din);
    int x, y, r, cy, npc;
    Reset = rst; X_sel = xs; Y_sel = ys; Addr_sel = as_;
    PC_En = pce; IR_En = ire; Acc_En = acce; Flag_En = fe;
    M = m; Push = psh; Pop = pp; Din = din;
    x  = xs ? m_pc : m_acc;
    y  = ys ? (m_ir & 'hFFF) : int'(din);
    cy = 0;
    case (m)
      3'd0: r = y;
      3'd1: begin r = x + y; cy = (r > 'hFFFF); end
      3'd2: begin r = x + 1; cy = (r > 'hFFFF); end
      3'd3: begin r = x - y; cy = (x < y); end
      3'd4: r = x & y;
      3'd5: r = x | y;
      3'd6: r = x ^ y;
      default: begin r = x / 2; cy = x % 2; end
    endcase
    r = r & 'hFFFF;
    @(posedge Clk);
    #1;
    if (rst) begin
      m_pc = 0; m_acc = 0; m_ir = 0; m_c = 0; m_err = 0;
      m_stk.delete();
    end else begin
      npc = pce ? (r & 'hFFF) : m_pc;
      if (psh && pp) m_err = 1;
      else if (psh) begin
        if (m_stk.size() == 4) m_err = 1;
        else m_stk.push_back(m_pc);
      end else if (pp) begin
        if (m_stk.size() == 0) m_err = 1;
        else npc = m_stk.pop_back();
      end
      if (ire)  m_ir  = din;
      if (acce) m_acc = r;
      if (fe)   m_c   = cy;
      m_pc = npc;
    end
    check_all();
  endtask

  initial begin
    // Reset with every enable high dominates
    step(1, 1, 1, 1, 1, 1, 1, 1, 3'd1, 1, 1, 16'hBEEF);
    check("rst_pc", 32'(PC), 32'h0);
    check("rst_z", 32'(Z), 32'h1);
    check("rst_empty", 32'(Stk_Empty), 32'h1);

    // IR load, operand to Acc
    step(0, 0, 0, 1, 0, 1, 0, 0, 3'd0, 0, 0, 16'h1005);
    step(0, 0, 1, 1, 0, 0, 1, 0, 3'd0, 0, 0, 16'h0000);
    check("tp_f", 32'(F), 32'h1);
    check("tp_addr", 32'(Address), 32'h005);
    check("tp_acc5", 32'(Acc), 32'h0005);

    // Add with carry out, then subtract with borrow
    step(0, 0, 0, 0, 0, 0, 1, 0, 3'd0, 0, 0, 16'hFFFF);
    step(0, 0, 0, 0, 0, 0, 1, 1, 3'd1, 0, 0, 16'h0001);
    check("add_acc", 32'(Acc), 32'h0);
    check("add_c", 32'(C), 32'h1);
    step(0, 0, 0, 0, 0, 0, 1, 1, 3'd3, 0, 0, 16'h0001);
    check("sub_acc", 32'(Acc), 32'hFFFF);
    check("sub_n", 32'(N), 32'h1);
    check("sub_c", 32'(C), 32'h1);

    // JSR / RTS
    step(0, 0, 0, 0, 0, 1, 0, 0, 3'd0, 0, 0, 16'h0010);
    step(0, 0, 1, 0, 1, 0, 0, 0, 3'd0, 0, 0, 16'h0000);
    step(0, 0, 0, 0, 0, 1, 0, 0, 3'd0, 0, 0, 16'h0200);
    step(0, 0, 1, 0, 1, 0, 0, 0, 3'd0, 1, 0, 16'h0000);
    check("jsr_pc", 32'(PC), 32'h200);
    check("jsr_empty", 32'(Stk_Empty), 32'h0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 1, 16'h0000);
    check("rts_pc", 32'(PC), 32'h010);
    check("rts_empty", 32'(Stk_Empty), 32'h1);

    // Fill, overflow, drain in LIFO order, underflow
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 0, 1, 0, 0, 0, 3'd2, 1, 0, 16'h0000);
      if (i == 3) check("full4", 32'(Stk_Full), 32'h1);
    end
    check("ovf_err", 32'(Stk_Err), 32'h1);
    check("ovf_pc", 32'(PC), 32'h015);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 1, 16'h0000);
      check("lifo", 32'(PC), 32'(12'h013 - 12'(i)));
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 1, 16'h0000);
    check("unf_pc", 32'(PC), 32'h010);
    check("unf_err", 32'(Stk_Err), 32'h1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 16'h0000);
    check("err_clr", 32'(Stk_Err), 32'h0);

    // PC wrap, then push+pop together
    step(0, 0, 0, 0, 0, 1, 0, 0, 3'd0, 0, 0, 16'h0FFF);
    step(0, 0, 1, 0, 1, 0, 0, 0, 3'd0, 0, 0, 16'h0000);
    check("pc_fff", 32'(PC), 32'hFFF);
    step(0, 1, 0, 0, 1, 0, 0, 0, 3'd2, 0, 0, 16'h0000);
    check("pc_wrap", 32'(PC), 32'h000);
    step(0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 1, 0, 16'h0000);
    step(0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 1, 1, 16'h0000);
    check("pp_empty", 32'(Stk_Empty), 32'h0);
    check("pp_err", 32'(Stk_Err), 32'h1);

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(31) == 0), 1'($urandom_range(1)), 1'($urandom_range(1)),
           1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
           1'($urandom_range(1)), 1'($urandom_range(1)), 3'($urandom_range(7)),
           1'($urandom_range(3) == 0), 1'($urandom_range(3) == 0),
           16'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mu0x_datapath.md
Name: mu0x_datapath

Overview:
- Parametrised next-generation MU0 datapath: configurable data and address widths, an extended 3-bit ALU mode set, a registered carry flag, and a hardware return-address stack for subroutine call and return.
- Sits between the MU0 control FSM and memory, replacing the fixed 16/12-bit datapath.
- Register enables, mux selects, ALU mode and stack push/pop all come from the controller.

Parameters:
- DATA_W, 16, data/instruction width; must satisfy DATA_W >= ADDR_W+4.
- ADDR_W, 12, address and PC width.
- STACK_DEPTH, 4, number of return-stack entries (2..16).
- PC_RESET, 0, PC value after reset.

Ports:
- Clk  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset; sampled on the rising Clk edge.
- Din  in  DATA_W  memory read data.
- X_sel  in  1  0: X=Acc; 1: X=PC zero-extended.
- Y_sel  in  1  0: Y=Din; 1: Y=IR[ADDR_W-1:0] zero-extended.
- Addr_sel  in  1  0: Address=PC; 1: Address=IR[ADDR_W-1:0].
- PC_En  in  1  PC loads ALU[ADDR_W-1:0].
- IR_En  in  1  IR loads Din.
- Acc_En  in  1  Acc loads ALU result.
- Flag_En  in  1  C loads ALU carry.
- M  in  3  ALU mode.
- Push  in  1  push current PC onto return stack.
- Pop  in  1  PC loads top of return stack.
- F  out  4  IR[DATA_W-1:DATA_W-4].
- Address  out  ADDR_W  memory address.
- Dout  out  DATA_W  equals X.
- N  out  1  Acc[DATA_W-1], combinational.
- Z  out  1  Acc==0, combinational.
- C  out  1  registered carry/borrow.
- PC  out  ADDR_W  program counter.
- Acc  out  DATA_W  accumulator.
- Stk_Empty  out  1  stack pointer == 0.
- Stk_Full  out  1  stack pointer == STACK_DEPTH.
- Stk_Err  out  1  sticky stack-misuse flag.

Behaviour:
- Reset (dominates all enables): PC=PC_RESET, Acc=0, IR=0, C=0, SP=0, Stk_Err=0.
  - Outputs after reset: F=0, N=0, Z=1, Stk_Empty=1, Stk_Full=0.
  - Stack entry contents are not reset.
- Registers update only on the rising Clk edge; all outputs other than registers are combinational from register state and inputs.
- ALU is combinational, computed on DATA_W bits, with carry c:
  - 000: Y, c=0.
  - 001: X+Y, c=carry out.
  - 010: X+1, c=carry out.
  - 011: X-Y, c=1 iff X<Y unsigned.
  - 100: X&Y, c=0.
  - 101: X|Y, c=0.
  - 110: X^Y, c=0.
  - 111: X>>1 logical, c=X[0].
- PC load truncates the ALU result to ADDR_W bits; wrap-around from all-ones to 0 is legal with no flag.
- Return stack: STACK_DEPTH×ADDR_W storage; SP ranges 0..STACK_DEPTH.
- Push only, SP<STACK_DEPTH: stack[SP]<=PC (value before the edge), SP<=SP+1. PC still obeys PC_En in the same cycle, giving a JSR in one cycle (Push+PC_En, X_sel=0 irrelevant, M=000, Y_sel=1).
- Pop only, SP>0: PC<=stack[SP-1], SP<=SP-1. Pop has priority over PC_En.
- Push when full: no stack change, Stk_Err<=1, PC obeys PC_En.
- Pop when empty: no stack change, Stk_Err<=1, PC obeys PC_En.
- Push and Pop together: no stack change, Stk_Err<=1, PC obeys PC_En.
- Stk_Err is cleared only by Reset.
- IR, Acc and C load independently of the stack operations. Simultaneous enables are all honoured, using pre-edge values.

Test Plan:
- Reset asserted with all enables high for one edge -> PC=0, Acc=0, IR=0, C=0, Z=1, Stk_Empty=1, Stk_Err=0.
- IR_En with Din=16'h1005; then Y_sel=1, M=000, Acc_En -> F=4'h1, Address=12'h005 when Addr_sel=1, Acc=16'h0005.
- Acc=16'hFFFF, Din=16'h0001, M=001, Acc_En, Flag_En -> Acc=0, Z=1, C=1. Then M=011, Y_sel=0 with Din=1 -> Acc=16'hFFFF, N=1, C=1 (borrow).
- PC=12'h010, Push+PC_En, IR operand 12'h200, Y_sel=1, M=000 -> PC=12'h200, SP=1. Then Pop -> PC=12'h010, Stk_Empty=1.
- With STACK_DEPTH=4: five pushes -> Stk_Full=1 after the fourth, Stk_Err=1 after the fifth, stack unchanged. Four pops return the pushed PCs in LIFO order; a fifth pop keeps PC and Stk_Err stays 1 until Reset.
- PC=12'hFFF, X_sel=1, M=010, PC_En -> PC=12'h000; Push and Pop in the same cycle -> SP unchanged, Stk_Err=1.
